// File: rtl/ifetch_ctrl_if.sv
// Fetch-controller bus bundle: program counter, instruction memory and decoder.
// The master side is the fetch controller; the slave side is its environment.
interface ifetch_ctrl_if;
  logic [15:0] pc_addr;
  logic        pcinc;
  logic        pcload;
  logic [15:0] pc_din;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        jmp_req;
  logic [15:0] jmp_target;
  logic [7:0]  fetch_cnt;
  logic        err;

  modport master (
    input  pc_addr, mem_ack, mem_data,
    input  ir_ready, jmp_req, jmp_target,
    output pcinc, pcload, pc_din,
    output mem_rd, mem_addr,
    output ir, ir_valid, fetch_cnt, err
  );

  modport slave (
    output pc_addr, mem_ack, mem_data,
    output ir_ready, jmp_req, jmp_target,
    input  pcinc, pcload, pc_din,
    input  mem_rd, mem_addr,
    input  ir, ir_valid, fetch_cnt, err
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: reads memory at the PC, holds the word for the
// decoder, steps or redirects the PC and flags memory timeouts.
module ifetch_ctrl (
  input logic           clk,
  input logic           rst,
  ifetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    JUMP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [15:0] r_pc_din;
  logic [7:0]  r_fetch_cnt;
  logic [3:0]  r_wait;
  logic        r_err;
  logic        r_hold_first;
  logic        w_in_fetch;
  logic        w_ack;
  logic        w_timeout;
  logic        w_jump;
  logic        w_fetch_entry;

  assign w_in_fetch    = (r_state == FETCH);
  assign w_ack         = w_in_fetch && bus.mem_ack;
  assign w_timeout     = w_in_fetch && !bus.mem_ack
                         && (r_wait == 4'hF);
  assign w_jump        = (r_state == HOLD) && bus.ir_ready
                         && bus.jmp_req;
  assign w_fetch_entry = (w_next == FETCH) && !w_in_fetch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = FETCH;
      FETCH: if (bus.mem_ack) w_next = HOLD;
      HOLD: begin
        if (bus.ir_ready) begin
          w_next = bus.jmp_req ? JUMP : FETCH;
        end
      end
      JUMP:  w_next = FETCH;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir         <= '0;
      r_pc_din     <= '0;
      r_fetch_cnt  <= '0;
      r_wait       <= '0;
      r_err        <= 1'b0;
      r_hold_first <= 1'b0;
    end else begin
      r_hold_first <= w_ack;
      if (w_ack) begin
        r_ir        <= bus.mem_data;
        r_fetch_cnt <= r_fetch_cnt + 8'd1;
      end
      if (w_jump) begin
        r_pc_din <= bus.jmp_target;
      end
      // An ack in the 16th wait cycle wins over the timeout.
      if (w_fetch_entry || w_timeout) begin
        r_wait <= '0;
      end else if (w_in_fetch && !bus.mem_ack) begin
        r_wait <= r_wait + 4'd1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.mem_rd    = w_in_fetch;
  assign bus.mem_addr  = w_in_fetch ? bus.pc_addr : '0;
  assign bus.ir        = r_ir;
  assign bus.ir_valid  = (r_state == HOLD);
  assign bus.pcinc     = (r_state == HOLD) && r_hold_first;
  assign bus.pcload    = (r_state == JUMP);
  assign bus.pc_din    = r_pc_din;
  assign bus.fetch_cnt = r_fetch_cnt;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a small program-counter model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] tb_pc;
  int          n_chk;
  int          n_err;
  int          n_inc;
  int          base;

  ifetch_ctrl_if bus ();

  ifetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.pc_addr = tb_pc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tb_pc <= '0;
    end else if (bus.pcload) begin
      tb_pc <= bus.pc_din;
    end else if (bus.pcinc) begin
      tb_pc <= tb_pc + 16'd1;
    end
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("pc_excl", 16'(bus.pcinc & bus.pcload), 16'h0);
    if (bus.pcinc) n_inc++;
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk_rst();
    chk("rst_mem_rd", 16'(bus.mem_rd), 16'h0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0);
    chk("rst_ir", bus.ir, 16'h0);
    chk("rst_ir_valid", 16'(bus.ir_valid), 16'h0);
    chk("rst_pcinc", 16'(bus.pcinc), 16'h0);
    chk("rst_pcload", 16'(bus.pcload), 16'h0);
    chk("rst_pc_din", bus.pc_din, 16'h0);
    chk("rst_fetch_cnt", 16'(bus.fetch_cnt), 16'h0);
    chk("rst_err", 16'(bus.err), 16'h0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    n_inc = 0;
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_data = '0;
    bus.ir_ready = 1'b0;
    bus.jmp_req = 1'b0;
    bus.jmp_target = '0;

    nxt();
    chk_rst();
    rst = 1'b1;
    #1 chk("idle_rd", 16'(bus.mem_rd), 16'h0);

    // sequential fetch at PC 0, ack one cycle after mem_rd
    nxt();
    chk("f0_rd", 16'(bus.mem_rd), 16'h1);
    chk("f0_addr", bus.mem_addr, 16'h0000);
    bus.ir_ready = 1'b1;
    nxt();
    chk("f0_rd2", 16'(bus.mem_rd), 16'h1);
    bus.mem_ack = 1'b1;
    bus.mem_data = 16'h1234;
    nxt();
    bus.mem_ack = 1'b0;
    chk("seq_ir", bus.ir, 16'h1234);
    chk("seq_valid", 16'(bus.ir_valid), 16'h1);
    chk("seq_pcinc", 16'(bus.pcinc), 16'h1);
    chk("seq_cnt", 16'(bus.fetch_cnt), 16'h1);
    chk("seq_rd_hold", 16'(bus.mem_rd), 16'h0);
    nxt();
    chk("seq_valid_off", 16'(bus.ir_valid), 16'h0);
    chk("seq_pcinc_off", 16'(bus.pcinc), 16'h0);
    chk("seq_rd", 16'(bus.mem_rd), 16'h1);
    chk("seq_addr", bus.mem_addr, 16'h0001);
    chk("seq_ninc", 16'(n_inc), 16'h1);

    // decoder backpressure; acks and jumps during HOLD are ignored
    base = n_inc;
    bus.ir_ready = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_data = 16'hABCD;
    nxt();
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 16'(bus.ir_valid), 16'h1);
      chk("bp_ir", bus.ir, 16'hABCD);
      chk("bp_rd", 16'(bus.mem_rd), 16'h0);
      chk("bp_pcload", 16'(bus.pcload), 16'h0);
      bus.mem_ack = 1'b1;
      bus.mem_data = 16'h5555;
      bus.jmp_req = 1'b1;
      bus.jmp_target = 16'h1111;
      if (i == 5) begin
        bus.mem_ack = 1'b0;
        bus.jmp_req = 1'b0;
        bus.ir_ready = 1'b1;
      end
      nxt();
    end
    chk("bp_rd_after", 16'(bus.mem_rd), 16'h1);
    chk("bp_addr", bus.mem_addr, 16'h0002);
    chk("bp_cnt", 16'(bus.fetch_cnt), 16'h2);
    chk("bp_ninc", 16'(n_inc - base), 16'h1);
    chk("bp_pc_din", bus.pc_din, 16'h0000);

    // jump to 0x00F0
    bus.mem_ack = 1'b1;
    bus.mem_data = 16'h00AA;
    bus.jmp_req = 1'b1;
    bus.jmp_target = 16'h00F0;
    nxt();
    bus.mem_ack = 1'b0;
    chk("j_ir", bus.ir, 16'h00AA);
    chk("j_cnt", 16'(bus.fetch_cnt), 16'h3);
    nxt();
    chk("j_pcload", 16'(bus.pcload), 16'h1);
    chk("j_pc_din", bus.pc_din, 16'h00F0);
    chk("j_pcinc", 16'(bus.pcinc), 16'h0);
    chk("j_rd", 16'(bus.mem_rd), 16'h0);
    chk("j_valid", 16'(bus.ir_valid), 16'h0);
    bus.jmp_req = 1'b0;
    nxt();
    chk("j_fetch_rd", 16'(bus.mem_rd), 16'h1);
    chk("j_fetch_addr", bus.mem_addr, 16'h00F0);
    chk("j_pcload_off", 16'(bus.pcload), 16'h0);

    // timeout: 20 cycles without ack, then a late ack
    bus.ir_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      chk("to_err", 16'(bus.err), (i <= 16) ? 16'h0 : 16'h1);
      chk("to_rd", 16'(bus.mem_rd), 16'h1);
      nxt();
    end
    chk("to_err21", 16'(bus.err), 16'h1);
    chk("to_addr", bus.mem_addr, 16'h00F0);
    bus.mem_ack = 1'b1;
    bus.mem_data = 16'hBEEF;
    nxt();
    bus.mem_ack = 1'b0;
    chk("to_ir", bus.ir, 16'hBEEF);
    chk("to_err_keep", 16'(bus.err), 16'h1);
    chk("to_cnt", 16'(bus.fetch_cnt), 16'h4);
    chk("to_valid", 16'(bus.ir_valid), 16'h1);

    // asynchronous reset in HOLD
    #2 rst = 1'b0;
    #1 chk_rst();
    nxt();
    chk_rst();
    rst = 1'b1;
    #1 chk("rel_idle_rd", 16'(bus.mem_rd), 16'h0);
    nxt();
    chk("rel_rd", 16'(bus.mem_rd), 16'h1);
    chk("rel_addr", bus.mem_addr, 16'h0000);

    // ack in the 16th wait cycle wins
    bus.ir_ready = 1'b1;
    for (int i = 1; i <= 15; i++) nxt();
    chk("a16_err_pre", 16'(bus.err), 16'h0);
    bus.mem_ack = 1'b1;
    bus.mem_data = 16'h0F0F;
    nxt();
    bus.mem_ack = 1'b0;
    chk("a16_ir", bus.ir, 16'h0F0F);
    chk("a16_err", 16'(bus.err), 16'h0);
    chk("a16_cnt", 16'(bus.fetch_cnt), 16'h1);
    nxt();
    chk("a16_err_late", 16'(bus.err), 16'h0);

    // 255 more fetches make 256 since reset
    for (int n = 1; n <= 255; n++) begin
      bus.mem_ack = 1'b1;
      bus.mem_data = 16'(n);
      nxt();
      bus.mem_ack = 1'b0;
      if (n == 254) chk("wrap_255", 16'(bus.fetch_cnt), 16'h00FF);
      nxt();
    end
    chk("wrap_0", 16'(bus.fetch_cnt), 16'h0000);
    chk("wrap_ir", bus.ir, 16'h00FF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 The block SHALL use clock clk, input, 1 bit, with all state updating on the rising edge.
REQ-002 The block SHALL use reset rst, input, 1 bit, asynchronous, active-low.
REQ-003 pc_addr  in  16  current PC value from the program counter.
REQ-004 pcinc  out  1  PC+1 request to the program counter.
REQ-005 pcload  out  1  PC load request to the program counter.
REQ-006 pc_din  out  16  jump target driven to the program counter's data input.
REQ-007 mem_rd  out  1  instruction memory read request.
REQ-008 mem_addr  out  16  instruction memory address.
REQ-009 mem_ack  in  1  memory has valid data on mem_data this cycle.
REQ-010 mem_data  in  16  instruction word from memory.
REQ-011 ir  out  16  instruction register.
REQ-012 ir_valid  out  1  ir holds an instruction not yet accepted by the decoder.
REQ-013 ir_ready  in  1  decoder accepts ir this cycle.
REQ-014 jmp_req  in  1  decoder redirect request, qualified by ir_ready.
REQ-015 jmp_target  in  16  redirect address, valid with jmp_req.
REQ-016 fetch_cnt  out  8  completed-fetch counter.
REQ-017 err  out  1  sticky memory-timeout flag.

Function
REQ-018 The block SHALL implement the FSM states IDLE, FETCH, HOLD and JUMP, and after reset SHALL spend exactly one cycle in IDLE before moving to FETCH.
REQ-019 FETCH: mem_rd=1 and mem_addr=pc_addr (combinational) throughout the state; in all other states mem_rd=0 and mem_addr=0.
REQ-020 FETCH with mem_ack=1: ir<=mem_data, fetch_cnt<=fetch_cnt+1 (mod 256, 255 wraps to 0), next state HOLD.
REQ-021 pcinc SHALL be 1 for exactly the first cycle of each HOLD state and 0 otherwise, so the PC advances at the end of that cycle.
REQ-022 HOLD: ir_valid=1 in every HOLD cycle, and ir_valid=0 in every other state.
REQ-023 HOLD with ir_ready=1 and jmp_req=0: next state FETCH.
REQ-024 HOLD with ir_ready=1 and jmp_req=1: pc_din<=jmp_target, next state JUMP.
REQ-025 HOLD with ir_ready=0: remain in HOLD, with ir held stable and jmp_req ignored.
REQ-026 HOLD minimum length: one cycle, so that FETCH always sees the incremented PC even when ir_ready=1 in the first HOLD cycle.
REQ-027 JUMP: lasts one cycle with pcload=1, next state FETCH; pcload SHALL be 0 in all other states.
REQ-028 pcinc and pcload SHALL never both be 1 in the same cycle.
REQ-029 Timeout: a 4-bit wait counter SHALL clear on FETCH entry and increment each FETCH cycle without mem_ack.
REQ-030 On the 16th consecutive cycle without mem_ack, err SHALL be set to 1, the wait counter SHALL clear, and the block SHALL stay in FETCH with mem_rd held at 1.
REQ-031 mem_ack outside FETCH SHALL be ignored, with no change to ir or fetch_cnt.
REQ-032 A mem_ack on the same cycle as the 16th wait cycle SHALL win: data is captured and err is not set.

Reset
REQ-033 While rst=0 the block SHALL hold state=IDLE, ir=0, ir_valid=0, mem_rd=0, pcinc=0, pcload=0, pc_din=0, fetch_cnt=0, err=0, and wait counter=0.
REQ-034 Reset asserted mid-FETCH or mid-HOLD SHALL immediately force all reset values, and the in-flight fetch SHALL be discarded.
REQ-035 err SHALL be cleared only by reset.

Verification
REQ-036 Sequential fetch: the bench SHALL apply PC=0x0000, mem_ack one cycle after mem_rd with data 0x1234, and ir_ready=1, and SHALL check ir=0x1234, ir_valid for 1 cycle, one pcinc pulse, next fetch at 0x0001, and fetch_cnt=1.
REQ-037 Decoder backpressure: the bench SHALL hold ir_ready=0 for 5 cycles and SHALL check that ir_valid stays 1, ir is stable, only one pcinc is issued, and mem_rd=0 throughout.
REQ-038 Jump: in HOLD the bench SHALL apply ir_ready=1, jmp_req=1, jmp_target=0x00F0, and SHALL check one JUMP cycle with pcload=1 and pc_din=0x00F0, followed by FETCH with mem_addr=0x00F0.
REQ-039 Timeout: the bench SHALL withhold mem_ack for 20 cycles, and SHALL check err=1 after the 16th cycle with mem_rd still 1, then a late ack captures data with err remaining 1.
REQ-040 Counter wrap: the bench SHALL complete 256 fetches and SHALL check fetch_cnt returns to 0.
REQ-041 Reset mid-operation: the bench SHALL drive rst=0 during HOLD with ir_valid=1, and SHALL check all outputs at reset values asynchronously, then after release one IDLE cycle before mem_rd=1.
